// File: rtl/legv8_ctrl_pkg.sv
// Shared encodings for the LEGv8 multi-cycle sequencer: states, opcodes,
// instruction classes and datapath mux selects.
package legv8_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_EXEC     = 4'd6,
    S_R_WB     = 4'd7,
    S_BRANCH   = 4'd8,
    S_JUMP     = 4'd9,
    S_HALT     = 4'd10
  } state_t;

  typedef enum logic [2:0] {
    C_RTYPE,
    C_LOAD,
    C_STORE,
    C_CBZ,
    C_B,
    C_ILLEGAL
  } iclass_t;

  localparam logic [10:0] OP_LDR = 11'b11111000010;
  localparam logic [10:0] OP_STR = 11'b11111000000;
  localparam logic [10:0] OP_ADD = 11'b10001011000;
  localparam logic [10:0] OP_SUB = 11'b11001011000;
  localparam logic [10:0] OP_AND = 11'b10001010000;
  localparam logic [10:0] OP_ORR = 11'b10101010000;
  localparam logic [5:0]  OP_B_PFX   = 6'b000101;
  localparam logic [7:0]  OP_CBZ_PFX = 8'b10110100;

  localparam logic [1:0] SRCA_PC      = 2'b00;
  localparam logic [1:0] SRCA_OLD_PC  = 2'b01;
  localparam logic [1:0] SRCA_REG     = 2'b10;
  localparam logic [1:0] SRCB_REG     = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;
  localparam logic [1:0] ALUOP_ADD    = 2'b00;
  localparam logic [1:0] ALUOP_PASS_B = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT  = 2'b10;

endpackage

// File: rtl/legv8_opcode_decode.sv
// Combinational classification of IR[31:21] into the instruction classes
// the sequencer branches on.
module legv8_opcode_decode
  import legv8_ctrl_pkg::*;
(
  input  logic [10:0] opcode,
  output iclass_t     iclass
);

  always_comb begin
    iclass = C_ILLEGAL;
    if (opcode[10:5] == OP_B_PFX) begin
      iclass = C_B;
    end else if (opcode[10:3] == OP_CBZ_PFX) begin
      iclass = C_CBZ;
    end else begin
      case (opcode)
        OP_LDR:                         iclass = C_LOAD;
        OP_STR:                         iclass = C_STORE;
        OP_ADD, OP_SUB, OP_AND, OP_ORR: iclass = C_RTYPE;
        default:                        iclass = C_ILLEGAL;
      endcase
    end
  end

endmodule

// File: rtl/legv8_multicycle_ctrl.sv
// Multi-cycle LEGv8 control sequencer with memory-ready stalls.
// Optional performance counters are built when LEGV8_MC_PERF_EN is defined.
module legv8_multicycle_ctrl
  import legv8_ctrl_pkg::*;
#(
  parameter int STATE_W = 4,
  parameter int CNT_W   = 32
) (
  input  logic               CLOCK,
  input  logic               RESET,
  input  logic [10:0]        OPCODE,
  input  logic               ALU_ZERO,
  input  logic               MEM_READY,
  output logic               PC_WRITE,
  output logic               PC_SRC,
  output logic               IR_WRITE,
  output logic               IORD,
  output logic               MEM_READ,
  output logic               MEM_WRITE,
  output logic               REG2LOC,
  output logic               REG_WRITE,
  output logic               MEM2REG,
  output logic [1:0]         ALUSRC_A,
  output logic [1:0]         ALUSRC_B,
  output logic [1:0]         ALU_OP,
  output logic               HALTED,
  output logic [STATE_W-1:0] STATE,
  output logic [CNT_W-1:0]   INSTR_COUNT,
  output logic [CNT_W-1:0]   CYCLE_COUNT
);

  state_t  state;
  iclass_t iclass;

  legv8_opcode_decode u_decode (
    .opcode (OPCODE),
    .iclass (iclass)
  );

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      state <= S_FETCH;
    end else begin
      case (state)
        S_FETCH:    if (MEM_READY) state <= S_DECODE;
        S_DECODE: begin
          case (iclass)
            C_B:              state <= S_JUMP;
            C_CBZ:            state <= S_BRANCH;
            C_LOAD, C_STORE:  state <= S_MEM_ADDR;
            C_RTYPE:          state <= S_EXEC;
            default:          state <= S_HALT;
          endcase
        end
        S_MEM_ADDR: state <= (iclass == C_LOAD) ? S_MEM_RD : S_MEM_WR;
        S_MEM_RD:   if (MEM_READY) state <= S_MEM_WB;
        S_MEM_WB:   state <= S_FETCH;
        S_MEM_WR:   if (MEM_READY) state <= S_FETCH;
        S_EXEC:     state <= S_R_WB;
        S_R_WB:     state <= S_FETCH;
        S_BRANCH:   state <= S_FETCH;
        S_JUMP:     state <= S_FETCH;
        S_HALT:     state <= S_HALT;
        default:    state <= S_HALT;
      endcase
    end
  end

  // Strobes decode from the current state; FETCH and BRANCH writes also follow inputs.
  always_comb begin
    PC_WRITE  = 1'b0;
    PC_SRC    = 1'b0;
    IR_WRITE  = 1'b0;
    IORD      = 1'b0;
    MEM_READ  = 1'b0;
    MEM_WRITE = 1'b0;
    REG2LOC   = 1'b0;
    REG_WRITE = 1'b0;
    MEM2REG   = 1'b0;
    ALUSRC_A  = SRCA_PC;
    ALUSRC_B  = SRCB_REG;
    ALU_OP    = ALUOP_ADD;
    HALTED    = 1'b0;
    case (state)
      S_FETCH: begin
        MEM_READ = 1'b1;
        ALUSRC_B = SRCB_FOUR;
        IR_WRITE = MEM_READY;
        PC_WRITE = MEM_READY;
      end
      S_DECODE: begin
        ALUSRC_A = SRCA_OLD_PC;
        ALUSRC_B = SRCB_IMM_SH2;
        REG2LOC  = (iclass == C_STORE) || (iclass == C_CBZ);
      end
      S_MEM_ADDR: begin
        ALUSRC_A = SRCA_REG;
        ALUSRC_B = SRCB_IMM;
        REG2LOC  = 1'b1;
      end
      S_MEM_RD: begin
        IORD     = 1'b1;
        MEM_READ = 1'b1;
      end
      S_MEM_WB: begin
        REG_WRITE = 1'b1;
        MEM2REG   = 1'b1;
      end
      S_MEM_WR: begin
        IORD      = 1'b1;
        MEM_WRITE = 1'b1;
        REG2LOC   = 1'b1;
      end
      S_EXEC: begin
        ALUSRC_A = SRCA_REG;
        ALU_OP   = ALUOP_FUNCT;
      end
      S_R_WB:   REG_WRITE = 1'b1;
      S_BRANCH: begin
        REG2LOC  = 1'b1;
        ALU_OP   = ALUOP_PASS_B;
        PC_SRC   = 1'b1;
        PC_WRITE = ALU_ZERO;
      end
      S_JUMP: begin
        PC_SRC   = 1'b1;
        PC_WRITE = 1'b1;
      end
      S_HALT:   HALTED = 1'b1;
      default:  HALTED = 1'b1;
    endcase
  end

  assign STATE = STATE_W'(state);

`ifdef LEGV8_MC_PERF_EN
  logic [CNT_W-1:0] cycle_cnt;
  logic [CNT_W-1:0] instr_cnt;
  logic             retire;

  // An instruction retires on the edge that returns the sequencer to FETCH.
  assign retire = (state == S_MEM_WB) || (state == S_R_WB) || (state == S_BRANCH) ||
                  (state == S_JUMP) || ((state == S_MEM_WR) && MEM_READY);

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      cycle_cnt <= '0;
      instr_cnt <= '0;
    end else begin
      if (state != S_HALT) cycle_cnt <= cycle_cnt + CNT_W'(1);
      if (retire)          instr_cnt <= instr_cnt + CNT_W'(1);
    end
  end

  assign CYCLE_COUNT = cycle_cnt;
  assign INSTR_COUNT = instr_cnt;
`else
  assign CYCLE_COUNT = '0;
  assign INSTR_COUNT = '0;
`endif

endmodule

// File: tb/tb_legv8_multicycle_ctrl.sv
// Directed bench for legv8_multicycle_ctrl: per-instruction state traces are
// generated from instruction class and stall counts, outputs checked each cycle.
module tb_legv8_multicycle_ctrl;

  localparam int STATE_W = 4;
  localparam int CNT_W   = 32;
`ifdef LEGV8_MC_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  localparam int K_R = 0, K_LD = 1, K_ST = 2, K_CBZ = 3, K_B = 4, K_ILL = 5;

  logic               CLOCK = 1'b0;
  logic               RESET = 1'b1;
  logic [10:0]        OPCODE = '0;
  logic               ALU_ZERO = 1'b0;
  logic               MEM_READY = 1'b0;
  logic               PC_WRITE, PC_SRC, IR_WRITE, IORD, MEM_READ, MEM_WRITE;
  logic               REG2LOC, REG_WRITE, MEM2REG, HALTED;
  logic [1:0]         ALUSRC_A, ALUSRC_B, ALU_OP;
  logic [STATE_W-1:0] STATE;
  logic [CNT_W-1:0]   INSTR_COUNT, CYCLE_COUNT;

  legv8_multicycle_ctrl #(.STATE_W(STATE_W), .CNT_W(CNT_W)) dut (
    .CLOCK(CLOCK), .RESET(RESET), .OPCODE(OPCODE), .ALU_ZERO(ALU_ZERO),
    .MEM_READY(MEM_READY), .PC_WRITE(PC_WRITE), .PC_SRC(PC_SRC),
    .IR_WRITE(IR_WRITE), .IORD(IORD), .MEM_READ(MEM_READ),
    .MEM_WRITE(MEM_WRITE), .REG2LOC(REG2LOC), .REG_WRITE(REG_WRITE),
    .MEM2REG(MEM2REG), .ALUSRC_A(ALUSRC_A), .ALUSRC_B(ALUSRC_B),
    .ALU_OP(ALU_OP), .HALTED(HALTED), .STATE(STATE),
    .INSTR_COUNT(INSTR_COUNT), .CYCLE_COUNT(CYCLE_COUNT)
  );

  always #5 CLOCK = ~CLOCK;

  typedef struct {
    int st;
    bit rdy;
  } step_t;

  step_t path[$];
  int    n_vec = 0;
  int    n_bad = 0;
  int    exp_st = 0;
  int    exp_cls = K_R;
  bit    chk = 1'b0;
  int    cyc_m = 0;
  int    ins_m = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Control word required in a given state:
  // {PC_WRITE,PC_SRC,IR_WRITE,IORD,MEM_READ,MEM_WRITE,REG2LOC,REG_WRITE,MEM2REG,A,B,OP,HALTED}
  function automatic logic [15:0] spec_out(input int st, input int cls, input logic rdy,
                                           input logic z);
    logic pcw = 0, pcs = 0, irw = 0, iord = 0, mr = 0, mw = 0;
    logic r2l = 0, rw = 0, m2r = 0, h = 0;
    logic [1:0] a = 2'b00, b = 2'b00, op = 2'b00;
    case (st)
      0:  begin mr = 1; b = 2'b01; irw = rdy; pcw = rdy; end
      1:  begin a = 2'b01; b = 2'b11; r2l = (cls == K_ST) || (cls == K_CBZ); end
      2:  begin a = 2'b10; b = 2'b10; r2l = 1; end
      3:  begin iord = 1; mr = 1; end
      4:  begin rw = 1; m2r = 1; end
      5:  begin iord = 1; mw = 1; r2l = 1; end
      6:  begin a = 2'b10; op = 2'b10; end
      7:  rw = 1;
      8:  begin r2l = 1; op = 2'b01; pcs = 1; pcw = z; end
      9:  begin pcs = 1; pcw = 1; end
      10: h = 1;
      default: h = 1;
    endcase
    return {pcw, pcs, irw, iord, mr, mw, r2l, rw, m2r, a, b, op, h};
  endfunction

  always @(negedge CLOCK) begin
    if (chk) begin
      check("ctrl", {PC_WRITE, PC_SRC, IR_WRITE, IORD, MEM_READ, MEM_WRITE, REG2LOC,
                     REG_WRITE, MEM2REG, ALUSRC_A, ALUSRC_B, ALU_OP, HALTED},
            spec_out(exp_st, exp_cls, MEM_READY, ALU_ZERO));
      check("state", STATE, exp_st);
      check("cycle_count", CYCLE_COUNT, PERF ? cyc_m : 0);
      check("instr_count", INSTR_COUNT, PERF ? ins_m : 0);
    end
  end

  // Expected state trace of one instruction; MEM_READY outside memory waits is random.
  task automatic build(input int cls, input int fw, input int mw);
    path.delete();
    repeat (fw) path.push_back('{0, 1'b0});
    path.push_back('{0, 1'b1});
    path.push_back('{1, 1'($urandom)});
    case (cls)
      K_R:   begin path.push_back('{6, 1'($urandom)}); path.push_back('{7, 1'($urandom)}); end
      K_LD: begin
        path.push_back('{2, 1'($urandom)});
        repeat (mw) path.push_back('{3, 1'b0});
        path.push_back('{3, 1'b1});
        path.push_back('{4, 1'($urandom)});
      end
      K_ST: begin
        path.push_back('{2, 1'($urandom)});
        repeat (mw) path.push_back('{5, 1'b0});
        path.push_back('{5, 1'b1});
      end
      K_CBZ: path.push_back('{8, 1'($urandom)});
      K_B:   path.push_back('{9, 1'($urandom)});
      default: repeat (12) path.push_back('{10, 1'($urandom)});
    endcase
  endtask

  task automatic step(input step_t s, input bit last, input int cls);
    MEM_READY = s.rdy;
    exp_st    = s.st;
    chk       = 1'b1;
    @(posedge CLOCK);
    if (s.st != 10) cyc_m++;
    if (last && cls != K_ILL) ins_m++;
    #1;
  endtask

  task automatic run_instr(input logic [10:0] op, input int cls, input logic z,
                           input int fw, input int mw);
    OPCODE   = op;
    ALU_ZERO = z;
    exp_cls  = cls;
    build(cls, fw, mw);
    foreach (path[i]) step(path[i], i == path.size() - 1, cls);
  endtask

  task automatic do_reset();
    chk   = 1'b0;
    RESET = 1'b1;
    #1;
    check("rst_state", STATE, 0);
    check("rst_halted", HALTED, 0);
    check("rst_mem_write", MEM_WRITE, 0);
    check("rst_cycle_count", CYCLE_COUNT, 0);
    check("rst_instr_count", INSTR_COUNT, 0);
    @(posedge CLOCK);
    #1;
    RESET = 1'b0;
    cyc_m = 0;
    ins_m = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #1;
    do_reset();

    run_instr(11'b10001011000, K_R, 1'b0, 0, 0);
    check("add_trace_len", path.size(), 4);
    check("add_instr_count", INSTR_COUNT, PERF ? 1 : 0);

    run_instr(11'b11111000010, K_LD, 1'b1, 0, 2);
    check("ldr_trace_len", path.size(), 7);

    run_instr(11'b10110100101, K_CBZ, 1'b1, 0, 0);
    check("cbz_taken_len", path.size(), 3);
    run_instr(11'b10110100011, K_CBZ, 1'b0, 0, 0);
    check("cbz_not_taken_len", path.size(), 3);

    run_instr(11'b00010110110, K_B, 1'b1, 0, 0);
    check("b_trace_len", path.size(), 3);

    run_instr(11'b11001011000, K_R, 1'b1, 2, 0);
    run_instr(11'b10001010000, K_R, 1'b0, 0, 0);
    run_instr(11'b10101010000, K_R, 1'b1, 1, 0);
    run_instr(11'b11111000000, K_ST, 1'b0, 0, 1);
    check("str_trace_len", path.size(), 5);
    run_instr(11'b11111000010, K_LD, 1'b0, 1, 0);

    do_reset();
    run_instr(11'b00000000000, K_ILL, 1'b1, 0, 0);
    check("halt_state", STATE, 10);
    check("halt_flag", HALTED, 1);
    check("halt_cycle_count", CYCLE_COUNT, PERF ? 2 : 0);
    check("halt_model_cycles", cyc_m, 2);
    do_reset();

    run_instr(11'b11111111111, K_ILL, 1'b0, 1, 0);
    do_reset();

    // Abort a store while it is waiting in MEM_WR.
    OPCODE  = 11'b11111000000;
    exp_cls = K_ST;
    build(K_ST, 0, 3);
    for (int i = 0; i < 5; i++) step(path[i], 1'b0, K_ST);
    chk       = 1'b0;
    MEM_READY = 1'b0;
    #2;
    check("pre_abort_state", STATE, 5);
    check("pre_abort_mem_write", MEM_WRITE, 1);
    do_reset();

    run_instr(11'b10001011000, K_R, 1'b0, 0, 0);
    check("post_abort_instr_count", INSTR_COUNT, PERF ? 1 : 0);

    chk = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
